// File: rtl/fifo_flops.sv
// Flop-based synchronous FIFO with first-word-fall-through output.
// Holds up to `depth` words; Dout shows the oldest word, or 0 when empty.
module fifo_flops #(
  parameter int depth = 8,
  parameter int bits  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] Din,
  input  logic            push,
  input  logic            pop,
  output logic [bits-1:0] Dout,
  output logic            full,
  output logic            pndng
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(depth);
  localparam logic [PW-1:0] PTR_MAX = PW'(depth - 1);

  logic [bits-1:0] mem [depth];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;

  logic do_push;
  logic do_pop;

  // A pop on a full FIFO frees the slot the simultaneous push lands in,
  // so the full check is waived whenever a real pop happens on the same edge.
  always_comb begin
    do_pop  = pop && (cnt != '0);
    do_push = push && ((cnt != CNT_MAX) || do_pop);
  end

  always_comb begin
    pndng = (cnt != '0);
    full  = (cnt == CNT_MAX);
    Dout  = pndng ? mem[rd_ptr] : '0;
  end

  // NOTE: all state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make ordering between blocks matter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: storage is reset too, so no stale word can ever reach Dout after a
  // reset; this costs a reset net on every bit, acceptable for a small flop FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= Din;
    end
  end

endmodule

// File: tb/tb_fifo_flops.sv
// Self-checking bench for fifo_flops: directed vector table, scoreboard-driven
// full/simultaneous and random wrap-around sequences, and async reset checks.
module tb_fifo_flops;

  localparam int DEPTH = 8;
  localparam int BITS  = 16;

  logic            clk;
  logic            rst;
  logic [BITS-1:0] din;
  logic            push;
  logic            pop;
  logic [BITS-1:0] dout;
  logic            full;
  logic            pndng;

  int n_checks = 0;
  int n_passed = 0;

  fifo_flops #(.depth(DEPTH), .bits(BITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .Din   (din),
    .push  (push),
    .pop   (pop),
    .Dout  (dout),
    .full  (full),
    .pndng (pndng)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            push;
    logic            pop;
    logic [BITS-1:0] din;
    logic [BITS-1:0] exp_dout;
    logic            exp_full;
    logic            exp_pndng;
  } vec_t;

  vec_t            vecs[$];
  logic [BITS-1:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_outs(input string name, input logic [BITS-1:0] e_dout,
                            input logic e_full, input logic e_pndng);
    check({name, ".dout"},  32'(dout),  32'(e_dout));
    check({name, ".full"},  32'(full),  32'(e_full));
    check({name, ".pndng"}, 32'(pndng), 32'(e_pndng));
  endtask

  // Drive inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic p, input logic q, input logic [BITS-1:0] d);
    push = p;
    pop  = q;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic p, input logic q, input logic [BITS-1:0] d,
                              input logic [BITS-1:0] e_dout, input logic e_full,
                              input logic e_pndng);
    vec_t v;
    v.push = p; v.pop = q; v.din = d;
    v.exp_dout = e_dout; v.exp_full = e_full; v.exp_pndng = e_pndng;
    vecs.push_back(v);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    push = 1'b0; pop = 1'b0; din = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
  endtask

  initial begin
    rst  = 1'b0;
    push = 1'b1;
    pop  = 1'b0;
    din  = 16'hAAAA;

    // Reset held 3 cycles with push active: nothing visible, nothing stored.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_outs($sformatf("rst_hold%0d", i), 16'h0000, 1'b0, 1'b0);
    end
    rst = 1'b1;
    step(1'b0, 1'b0, 16'h0000);
    check_outs("rst_release", 16'h0000, 1'b0, 1'b0);

    // Directed table starting from empty.
    add(1, 0, 16'h1234, 16'h1234, 0, 1);
    add(0, 1, 16'h0000, 16'h0000, 0, 0);
    for (int k = 1; k <= DEPTH; k++)
      add(1, 0, BITS'(k), 16'h0001, (k == DEPTH), 1);
    add(1, 0, 16'h0009, 16'h0001, 1, 1);
    for (int k = 1; k <= DEPTH; k++)
      add(0, 1, 16'h0000, (k < DEPTH) ? BITS'(k + 1) : 16'h0000, 0, (k < DEPTH));
    add(0, 1, 16'h0000, 16'h0000, 0, 0);
    add(1, 1, 16'hBEEF, 16'hBEEF, 0, 1);
    add(0, 1, 16'h0000, 16'h0000, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].din);
      check_outs($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_full, vecs[i].exp_pndng);
    end

    // Simultaneous push/pop while full, then drain through the scoreboard.
    do_reset();
    for (int k = 1; k <= DEPTH; k++) begin
      step(1'b1, 1'b0, BITS'(k));
      sb.push_back(BITS'(k));
    end
    check("fill.full", 32'(full), 32'd1);
    check("pp_full.head", 32'(dout), 32'(sb.pop_front()));
    step(1'b1, 1'b1, 16'h00FF);
    sb.push_back(16'h00FF);
    check("pp_full.full", 32'(full), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain%0d", i), 32'(dout), 32'(sb.pop_front()));
      step(1'b0, 1'b1, 16'h0000);
    end
    check_outs("drain_end", 16'h0000, 1'b0, 1'b0);

    // Random interleaved traffic across the pointer wrap, checked against a queue.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      logic [BITS-1:0] w;
      w = BITS'($urandom);
      step(1'b1, 1'b0, w);
      sb.push_back(w);
    end
    for (int i = 0; i < 20; i++) begin
      logic p, q, dp;
      logic [BITS-1:0] w;
      p = ($urandom_range(0, 9) < 6);
      q = ($urandom_range(0, 9) < 5);
      w = BITS'($urandom);
      if (q && sb.size() > 0)
        check($sformatf("rnd%0d.head", i), 32'(dout), 32'(sb[0]));
      dp = q && (sb.size() > 0);
      step(p, q, w);
      if (dp) void'(sb.pop_front());
      if (p && (sb.size() < DEPTH)) sb.push_back(w);
      check($sformatf("rnd%0d.pndng", i), 32'(pndng), 32'(sb.size() != 0));
      check($sformatf("rnd%0d.full", i),  32'(full),  32'(sb.size() == DEPTH));
      check($sformatf("rnd%0d.dout", i),  32'(dout),  32'((sb.size() != 0) ? sb[0] : 16'h0000));
    end

    // Asynchronous reset mid-cycle with 5 words stored.
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, BITS'(16'h0100 + k));
    step(1'b0, 1'b0, 16'h0000);
    check_outs("pre_async", 16'h0100, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_outs("async_rst", 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b0, 1'b0, 16'h0000);
    check_outs("after_async", 16'h0000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
